// File: rtl/float_arb_pkg.sv
// Shared types and helpers for the float adder arbiter.
package float_arb_pkg;

  // Tag id field is sized for up to 2**MAX_ID_W requesters; ids are zero-extended into it.
  localparam int unsigned MAX_ID_W = 4;

  // Packed float width {sign, exponent, fraction}.
  function automatic int unsigned floatWidth(input int unsigned expW, input int unsigned fracW);
    return 1 + expW + fracW;
  endfunction

  // One stage of the in-flight tag pipeline.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or above ptr (wrapping) wins.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grantIdx,
  output logic             grantValid
);

  logic [IDX_W-1:0] cand;

  // Scan from ptr upward, modulo N, and keep the first hit.
  always_comb begin
    grant      = '0;
    grantIdx   = '0;
    grantValid = 1'b0;
    cand       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!grantValid && req[cand]) begin
        grant[cand] = 1'b1;
        grantIdx    = cand;
        grantValid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/float_add_arbiter.sv
// Shares one pipelined float adder between NUM_REQ requesters with tagged result steering.
module float_add_arbiter
  import float_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned EXP           = 8,
  parameter int unsigned FRAC          = 23,
  parameter int unsigned TRAILING_BITS = 2,
  parameter int unsigned ADD_LATENCY   = 1
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*(1+EXP+FRAC)-1:0]     req_a,
  input  logic [NUM_REQ*(1+EXP+FRAC)-1:0]     req_b,
  input  logic [NUM_REQ-1:0]                  req_sub,
  output logic [EXP+FRAC:0]                   add_a,
  output logic [EXP+FRAC:0]                   add_b,
  output logic                                add_sub,
  output logic                                add_reset,
  input  logic [EXP+FRAC:0]                   add_out,
  input  logic [TRAILING_BITS-1:0]            add_trail,
  input  logic                                add_sticky,
  input  logic                                add_nan,
  output logic [NUM_REQ-1:0]                  res_valid,
  input  logic [NUM_REQ-1:0]                  res_ready,
  output logic [NUM_REQ*(1+EXP+FRAC)-1:0]     res_data,
  output logic [NUM_REQ*TRAILING_BITS-1:0]    res_trail,
  output logic [NUM_REQ-1:0]                  res_sticky,
  output logic [NUM_REQ-1:0]                  res_nan
);

  localparam int unsigned FW   = floatWidth(EXP, FRAC);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] inflight;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] retire;
  logic [ID_W-1:0]    rrPtr;
  logic [ID_W-1:0]    grantIdx;
  logic               grantValid;
  tag_t               tagPipe [ADD_LATENCY];
  tag_t               lastTag;

  // One op in flight per requester, and its slot must be free or draining this cycle.
  assign elig = req_valid & ~inflight & (~res_valid | res_ready) & {NUM_REQ{reset_n}};

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) uArb (
    .req        (elig),
    .ptr        (rrPtr),
    .grant      (grant),
    .grantIdx   (grantIdx),
    .grantValid (grantValid)
  );

  assign req_ready = grant;
  assign add_reset = ~reset_n;
  assign lastTag   = tagPipe[ADD_LATENCY-1];

  // Steer the granted requester's operands onto the shared adder; zeros when idle.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        add_a   = req_a[i*FW +: FW];
        add_b   = req_b[i*FW +: FW];
        add_sub = req_sub[i];
      end
    end
  end

  // Decode which requester's result is arriving from the adder this cycle.
  always_comb begin
    retire = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (lastTag.valid && (lastTag.id == MAX_ID_W'(i))) retire[i] = 1'b1;
    end
  end

  // Round-robin pointer advances past the winner, holds when nobody is granted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rrPtr <= '0;
    end else if (grantValid) begin
      rrPtr <= (32'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + ID_W'(1);
    end
  end

  // Tag pipeline tracks which requester owns each adder stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < int'(ADD_LATENCY); s++) tagPipe[s] <= '0;
    end else begin
      tagPipe[0].valid <= grantValid;
      tagPipe[0].id    <= MAX_ID_W'(grantIdx);
      for (int s = 1; s < int'(ADD_LATENCY); s++) tagPipe[s] <= tagPipe[s-1];
    end
  end

  // In-flight flags: a new grant wins over a same-cycle retire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
    end else begin
      inflight <= (inflight & ~retire) | grant;
    end
  end

  // Result slots: load on retire, otherwise drop valid on consume; data holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_valid  <= '0;
      res_data   <= '0;
      res_trail  <= '0;
      res_sticky <= '0;
      res_nan    <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (retire[i]) begin
          res_valid[i]                              <= 1'b1;
          res_data[i*FW +: FW]                      <= add_out;
          res_trail[i*TRAILING_BITS +: TRAILING_BITS] <= add_trail;
          res_sticky[i]                             <= add_sticky;
          res_nan[i]                                <= add_nan;
        end else if (res_valid[i] && res_ready[i]) begin
          res_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_float_add_arbiter.sv
// Randomized bench for float_add_arbiter with a cycle-level reference model and a stand-in adder.
module tb_float_add_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned FW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset_n, reset2_n;
  logic [NR-1:0]    req_valid, req_sub, res_ready;
  logic [NR*FW-1:0] req_a, req_b;

  logic [NR-1:0]    req_ready1, res_valid1, res_sticky1, res_nan1;
  logic [FW-1:0]    add_a1, add_b1, add_out1;
  logic             add_sub1, add_reset1, add_sticky1, add_nan1;
  logic [1:0]       add_trail1;
  logic [NR*FW-1:0] res_data1;
  logic [NR*2-1:0]  res_trail1;

  logic [NR-1:0]    req_ready2, res_valid2, res_sticky2, res_nan2;
  logic [FW-1:0]    add_a2, add_b2, add_out2;
  logic             add_sub2, add_reset2, add_sticky2, add_nan2;
  logic [1:0]       add_trail2;
  logic [NR*FW-1:0] res_data2;
  logic [NR*2-1:0]  res_trail2;

  float_add_arbiter #(.NUM_REQ(NR), .EXP(8), .FRAC(23), .TRAILING_BITS(2), .ADD_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_a(add_a1), .add_b(add_b1), .add_sub(add_sub1), .add_reset(add_reset1),
    .add_out(add_out1), .add_trail(add_trail1), .add_sticky(add_sticky1), .add_nan(add_nan1),
    .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1), .res_trail(res_trail1),
    .res_sticky(res_sticky1), .res_nan(res_nan1));

  float_add_arbiter #(.NUM_REQ(NR), .EXP(8), .FRAC(23), .TRAILING_BITS(2), .ADD_LATENCY(2)) dut2 (
    .clock(clock), .reset_n(reset2_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_a(add_a2), .add_b(add_b2), .add_sub(add_sub2), .add_reset(add_reset2),
    .add_out(add_out2), .add_trail(add_trail2), .add_sticky(add_sticky2), .add_nan(add_nan2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2), .res_trail(res_trail2),
    .res_sticky(res_sticky2), .res_nan(res_nan2));

  // Stand-in adder: exact on the two directed cases, an arbitrary bijective-ish mix otherwise.
  // Result layout {nan, sticky, trail[1:0], out[31:0]}.
  function automatic logic [35:0] fakeAdd(input logic [31:0] a, input logic [31:0] b, input logic sub);
    if (a == 32'h3F800000 && b == 32'h40000000 && !sub) return {4'b0000, 32'h40400000};
    if (a == 32'h7F800000 && b == 32'h7F800000 && sub)  return {4'b1000, 32'h7FC00000};
    return {a[31] & b[31] & sub, a[2] ^ b[3] ^ sub, a[1:0] ^ b[1:0],
            a ^ {b[15:0], b[31:16]} ^ {32{sub}}};
  endfunction

  logic [35:0] pipe1, pipe2a, pipe2b;
  always @(posedge clock) begin
    pipe1  <= fakeAdd(add_a1, add_b1, add_sub1);
    pipe2a <= fakeAdd(add_a2, add_b2, add_sub2);
    pipe2b <= pipe2a;
  end
  assign {add_nan1, add_sticky1, add_trail1, add_out1} = pipe1;
  assign {add_nan2, add_sticky2, add_trail2, add_out2} = pipe2b;

  // Reference model of dut1 (latency 1): per-requester busy/return-cycle plus slot contents.
  localparam int LAT1 = 1;
  logic        mBusy  [NR];
  int          mRet   [NR];
  logic [35:0] mPend  [NR];
  logic        mSlotV [NR];
  logic [35:0] mSlot  [NR];
  int          mPtr;
  int          cyc;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nextEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic randData();
    req_a   = {$urandom, $urandom, $urandom, $urandom};
    req_b   = {$urandom, $urandom, $urandom, $urandom};
    req_sub = 4'($urandom);
  endtask

  // Compare dut1 against the model for the current cycle, then advance the model across the edge.
  task automatic checkAndModel();
    int            g;
    int            idx;
    logic [NR-1:0] expGrant;
    logic [31:0]   expA, expB;
    logic          expSub;
    #1;
    if (!reset_n) begin
      checkVal("rst_ready", req_ready1, 0);
      checkVal("rst_res_valid", res_valid1, 0);
      checkVal("rst_res_data", res_data1, 0);
      checkVal("rst_add_a", add_a1, 0);
      checkVal("rst_add_reset", add_reset1, 1);
    end else begin
      g = -1;
      for (int k = 0; k < int'(NR); k++) begin
        idx = (mPtr + k) % NR;
        if (g < 0 && req_valid[idx] && !mBusy[idx] && (!mSlotV[idx] || res_ready[idx])) g = idx;
      end
      expGrant = '0; expA = '0; expB = '0; expSub = 1'b0;
      if (g >= 0) begin
        expGrant[g] = 1'b1;
        expA   = req_a[g*FW +: FW];
        expB   = req_b[g*FW +: FW];
        expSub = req_sub[g];
      end
      checkVal("grant", req_ready1, expGrant);
      checkVal("add_a", add_a1, expA);
      checkVal("add_b", add_b1, expB);
      checkVal("add_sub", add_sub1, expSub);
      checkVal("add_reset", add_reset1, 0);
      for (int i = 0; i < int'(NR); i++) begin
        checkVal($sformatf("res_valid%0d", i), res_valid1[i], mSlotV[i]);
        checkVal($sformatf("res_data%0d", i), res_data1[i*FW +: FW], mSlot[i][31:0]);
        checkVal($sformatf("res_flags%0d", i),
                 {res_nan1[i], res_sticky1[i], res_trail1[i*2 +: 2]}, mSlot[i][35:32]);
      end
      for (int i = 0; i < int'(NR); i++) begin
        if (mBusy[i] && mRet[i] == cyc) begin
          mSlotV[i] = 1'b1;
          mSlot[i]  = mPend[i];
          mBusy[i]  = 1'b0;
        end else if (mSlotV[i] && res_ready[i]) begin
          mSlotV[i] = 1'b0;
        end
      end
      if (g >= 0) begin
        mBusy[g] = 1'b1;
        mRet[g]  = cyc + LAT1;
        mPend[g] = fakeAdd(expA, expB, expSub);
        mPtr     = (g + 1) % NR;
      end
      cyc++;
    end
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    res_ready = '1;
    repeat (n) begin
      checkAndModel();
      nextEdge();
    end
  endtask

  initial begin
    reset_n = 1'b0; reset2_n = 1'b0;
    req_valid = '1; res_ready = '1;
    randData();
    mPtr = 0; cyc = 0;
    for (int i = 0; i < int'(NR); i++) begin
      mBusy[i] = 1'b0; mRet[i] = 0; mPend[i] = '0; mSlotV[i] = 1'b0; mSlot[i] = '0;
    end
    repeat (2) @(posedge clock);
    #1;

    // Reset held with every requester asking.
    repeat (3) begin
      checkAndModel();
      nextEdge();
    end
    reset_n = 1'b1;
    checkAndModel();
    checkVal("first_grant", req_ready1, 4'b0001);
    nextEdge();
    drain(4);

    // Single op 1.0 + 2.0 on requester 0.
    req_valid = 4'b0001; res_ready = '0; req_sub[0] = 1'b0;
    req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000;
    checkAndModel();
    checkVal("single_grant", req_ready1, 4'b0001);
    nextEdge();
    req_valid = '0;
    checkAndModel();
    checkVal("single_pending", res_valid1[0], 0);
    nextEdge();
    checkAndModel();
    checkVal("single_valid", res_valid1[0], 1);
    checkVal("single_data", res_data1[31:0], 32'h40400000);
    checkVal("single_sticky", res_sticky1[0], 0);
    checkVal("single_nan", res_nan1[0], 0);
    nextEdge();
    drain(3);

    // Everybody valid, all slots draining.
    req_valid = '1; res_ready = '1;
    repeat (12) begin
      randData();
      checkAndModel();
      nextEdge();
    end

    // Slot 2 never drained: requester 2 must starve once its slot fills.
    res_ready = 4'b1011;
    repeat (10) begin
      randData();
      checkAndModel();
      nextEdge();
    end
    checkAndModel();
    checkVal("bp_blocked", req_ready1[2], 0);
    checkVal("bp_slot2_full", res_valid1[2], 1);
    nextEdge();
    req_valid = 4'b0100; res_ready = '1;
    checkAndModel();
    checkVal("bp_release", req_ready1, 4'b0100);
    nextEdge();
    drain(4);

    // inf - inf on requester 1.
    req_valid = 4'b0010; res_ready = '0; req_sub[1] = 1'b1;
    req_a[63:32] = 32'h7F800000; req_b[63:32] = 32'h7F800000;
    checkAndModel();
    nextEdge();
    req_valid = '0;
    checkAndModel();
    nextEdge();
    checkAndModel();
    checkVal("nan_flag", res_nan1[1], 1);
    checkVal("nan_data", res_data1[63:32], 32'h7FC00000);
    nextEdge();
    drain(3);

    // Random traffic.
    repeat (300) begin
      req_valid = 4'($urandom);
      res_ready = 4'($urandom) | 4'($urandom);
      randData();
      checkAndModel();
      nextEdge();
    end
    drain(4);

    // Latency-2 instance: reset one cycle after issue discards the op and rewinds the pointer.
    req_valid = 4'b0001; res_ready = '1; reset2_n = 1'b1;
    checkAndModel();
    checkVal("d2_grant", req_ready2, 4'b0001);
    checkVal("d2_add_reset", add_reset2, 0);
    nextEdge();
    reset2_n = 1'b0; req_valid = '0;
    checkAndModel();
    checkVal("d2_rst_ready", req_ready2, 0);
    checkVal("d2_rst_res_valid", res_valid2, 0);
    checkVal("d2_rst_add_a", add_a2, 0);
    checkVal("d2_rst_add_reset", add_reset2, 1);
    nextEdge();
    reset2_n = 1'b1;
    repeat (5) begin
      checkAndModel();
      checkVal("d2_no_stale", res_valid2, 0);
      nextEdge();
    end
    req_valid = '1;
    checkAndModel();
    checkVal("d2_ptr_restart", req_ready2, 4'b0001);
    nextEdge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
